// File: rtl/sar_pkg.sv
// Shared state encoding and sizing helpers for the SAR ADC scan controller.
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_STORE
  } sar_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ch_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  function automatic logic [63:0] midscale(input int res);
    return 64'(1) << (res - 1);
  endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation bit engine: trial mask, partial result, settle counter and DAC code.
module sar_bit_engine import sar_pkg::*; #(
  parameter int RESOLUTION    = 12,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_conv_i,
  input  logic                  comp_i,
  output logic                  done_o,
  output logic [RESOLUTION-1:0] result_o,
  output logic [RESOLUTION-1:0] dac_o
);

  localparam int CW = (clog2(SETTLE_CYCLES + 1) < 1) ? 1 : clog2(SETTLE_CYCLES + 1);
  localparam logic [RESOLUTION-1:0] MID  = RESOLUTION'(midscale(RESOLUTION));
  localparam logic [CW-1:0]         LAST = CW'(SETTLE_CYCLES);

  logic [RESOLUTION-1:0] mask_q, mask_d, res_q, res_d, dac_q, dac_d, trial;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    mask_d = mask_q;
    res_d  = res_q;
    dac_d  = dac_q;
    cnt_d  = cnt_q;
    done_o = 1'b0;
    trial  = res_q | (comp_i ? mask_q : '0);
    if (start_conv_i) begin
      mask_d = MID;
      res_d  = '0;
      dac_d  = MID;
      cnt_d  = '0;
    end else if (mask_q != '0) begin
      // comp_i only counts in the last cycle of a trial, after the DAC has settled
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        res_d  = trial;
        mask_d = mask_q >> 1;
        dac_d  = trial | (mask_q >> 1);
        done_o = mask_q[0];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      res_q  <= '0;
      dac_q  <= MID;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      res_q  <= res_d;
      dac_q  <= dac_d;
      cnt_q  <= cnt_d;
    end
  end

  assign result_o = res_q;
  assign dac_o    = dac_q;

endmodule

// File: rtl/sar_adc_scan.sv
// Multi-channel SAR ADC controller: channel scan, track phase and valid/ready result stream.
module sar_adc_scan import sar_pkg::*; #(
  parameter int RESOLUTION    = 12,
  parameter int CHANNELS      = 4,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CH_W          = ch_width(CHANNELS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  continuous_i,
  input  logic [CHANNELS-1:0]   ch_mask_i,
  input  logic                  comp_i,
  output logic [CH_W-1:0]       mux_sel_o,
  output logic                  sample_o,
  output logic [RESOLUTION-1:0] dac_o,
  output logic [RESOLUTION-1:0] data_o,
  output logic [CH_W-1:0]       data_ch_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  busy_o
);

  localparam int SW = (clog2(SAMPLE_CYCLES) < 1) ? 1 : clog2(SAMPLE_CYCLES);
  localparam logic [SW-1:0]         SLAST = SW'(SAMPLE_CYCLES - 1);
  localparam logic [RESOLUTION-1:0] MID   = RESOLUTION'(midscale(RESOLUTION));

  sar_state_e            state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d, nxt_ch, low_ch;
  logic [CHANNELS-1:0]   mask_q, mask_d;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic [RESOLUTION-1:0] data_q, data_d, eng_res, eng_dac;
  logic [CH_W-1:0]       dch_q, dch_d;
  logic                  valid_q, valid_d, nxt_found, start_conv, conv_done;

  sar_bit_engine #(
    .RESOLUTION   (RESOLUTION),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_engine (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_conv_i(start_conv),
    .comp_i      (comp_i),
    .done_o      (conv_done),
    .result_o    (eng_res),
    .dac_o       (eng_dac)
  );

  // Downward scan leaves the lowest qualifying index in each result.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    low_ch    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
      if (ch_mask_i[i]) low_ch = CH_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    scnt_d     = scnt_q;
    data_d     = data_q;
    dch_d      = dch_q;
    valid_d    = valid_q;
    start_conv = 1'b0;
    if (valid_q && data_ready_i) valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (ch_mask_i != '0)) begin
          mask_d  = ch_mask_i;
          ch_d    = low_ch;
          scnt_d  = '0;
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        scnt_d = scnt_q + SW'(1);
        if (scnt_q == SLAST) begin
          start_conv = 1'b1;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) state_d = ST_STORE;
      end
      ST_STORE: begin
        // A held result is only replaced in the cycle the consumer takes it
        if (!valid_q || data_ready_i) begin
          data_d  = eng_res;
          dch_d   = ch_q;
          valid_d = 1'b1;
          scnt_d  = '0;
          if (nxt_found) begin
            ch_d    = nxt_ch;
            state_d = ST_SAMPLE;
          end else if (continuous_i && (ch_mask_i != '0)) begin
            mask_d  = ch_mask_i;
            ch_d    = low_ch;
            state_d = ST_SAMPLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      mask_q  <= '0;
      scnt_q  <= '0;
      data_q  <= '0;
      dch_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      scnt_q  <= scnt_d;
      data_q  <= data_d;
      dch_q   <= dch_d;
      valid_q <= valid_d;
    end
  end

  assign mux_sel_o    = ch_q;
  assign sample_o     = (state_q == ST_SAMPLE);
  assign dac_o        = ((state_q == ST_CONVERT) || (state_q == ST_STORE)) ? eng_dac : MID;
  assign data_o       = data_q;
  assign data_ch_o    = dch_q;
  assign data_valid_o = valid_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sar_adc_scan.sv
// Self-checking bench for sar_adc_scan with an ideal comparator and a per-channel Vin model.
module tb_sar_adc_scan;
  localparam int RES = 8, CHN = 4, SMP = 2, STL = 1, CHW = 2;
  localparam int LAT  = SMP + RES * (STL + 1) + 1;
  localparam int LAT0 = SMP + RES + 1;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic            start_i, continuous_i, comp_i, sample_o, data_valid_o, data_ready_i, busy_o;
  logic [CHN-1:0]  ch_mask_i;
  logic [CHW-1:0]  mux_sel_o, data_ch_o;
  logic [RES-1:0]  dac_o, data_o;
  logic [RES-1:0]  vin [CHN];

  logic            start_z, cont_z, comp_z, sample_z, valid_z, ready_z, busy_z;
  logic [CHN-1:0]  mask_z;
  logic [CHW-1:0]  mux_z, dch_z;
  logic [RES-1:0]  dac_z, data_z;
  logic [RES-1:0]  vin_z [CHN];

  assign comp_i = (vin[mux_sel_o] >= dac_o);
  assign comp_z = (vin_z[mux_z] >= dac_z);

  sar_adc_scan #(.RESOLUTION(RES), .CHANNELS(CHN), .SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(STL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .continuous_i(continuous_i),
    .ch_mask_i(ch_mask_i), .comp_i(comp_i), .mux_sel_o(mux_sel_o), .sample_o(sample_o),
    .dac_o(dac_o), .data_o(data_o), .data_ch_o(data_ch_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .busy_o(busy_o));

  sar_adc_scan #(.RESOLUTION(RES), .CHANNELS(CHN), .SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_z), .continuous_i(cont_z),
    .ch_mask_i(mask_z), .comp_i(comp_z), .mux_sel_o(mux_z), .sample_o(sample_z),
    .dac_o(dac_z), .data_o(data_z), .data_ch_o(dch_z), .data_valid_o(valid_z),
    .data_ready_i(ready_z), .busy_o(busy_z));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for result at %0t", name, $time);
  endtask

  // Waits for a handshake, checks it, and returns just after the accepting edge.
  task automatic get_result(input string name, input logic [CHW-1:0] ec, input logic [RES-1:0] ed);
    int c;
    c = 0;
    while (c < 200) begin
      @(negedge clk_i);
      if (data_valid_o && data_ready_i) break;
      c++;
    end
    if (c >= 200) timeout(name);
    else begin
      chk({name, "_ch"}, data_ch_o, ec);
      chk({name, "_data"}, data_o, ed);
    end
    @(posedge clk_i);
    #1;
  endtask

  // An unaccepted result must stay put.
  logic pv = 1'b0, pr = 1'b0;
  logic [RES-1:0] pd = '0;
  logic [CHW-1:0] pc = '0;
  always @(negedge clk_i) begin
    if (rst_ni && pv && !pr) begin
      chk("hold_valid", data_valid_o, 1);
      chk("hold_data", data_o, pd);
      chk("hold_ch", data_ch_o, pc);
    end
    pv = rst_ni && data_valid_o;
    pr = data_ready_i;
    pd = data_o;
    pc = data_ch_o;
  end

  typedef struct {
    logic [CHN-1:0]          mask;
    logic [CHN-1:0][RES-1:0] v;
    int                      n;
    logic [CHW-1:0]          ch_a;
    logic [RES-1:0]          d_a;
    logic [CHW-1:0]          ch_b;
    logic [RES-1:0]          d_b;
  } vec_t;

  typedef struct {
    logic [CHW-1:0] ch;
    logic [RES-1:0] d;
  } res_t;

  vec_t tbl [6];
  res_t exp_q [$];
  logic [RES-1:0] seq_a [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, k, c;
    logic [RES-1:0] ev;
    res_t r;

    rst_ni = 1'b0;
    start_i = 0; continuous_i = 0; ch_mask_i = '0; data_ready_i = 0;
    start_z = 0; cont_z = 0; mask_z = '0; ready_z = 0;
    for (int i = 0; i < CHN; i++) begin vin[i] = '0; vin_z[i] = '0; end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mux", mux_sel_o, 0);
    chk("rst_sample", sample_o, 0);
    chk("rst_dac", dac_o, 8'h80);
    chk("rst_data", data_o, 0);
    chk("rst_data_ch", data_ch_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;

    // Single-channel conversion: full DAC trial sequence and first-result latency
    seq_a = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin[0] = 8'hA5; ch_mask_i = 4'b0001; data_ready_i = 1;
    @(posedge clk_i); #1 start_i = 1;
    for (k = 0; k <= LAT; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 0;
      if (k < SMP) begin
        chk("a_sample_hi", sample_o, 1);
        chk("a_dac_mid", dac_o, 8'h80);
      end else if (k < SMP + RES * (STL + 1)) begin
        chk("a_sample_lo", sample_o, 0);
        chk("a_dac_trial", dac_o, seq_a[(k - SMP) / (STL + 1)]);
      end else if (k < LAT) begin
        chk("a_store_dac", dac_o, 8'hA5);
        chk("a_valid_early", data_valid_o, 0);
        chk("a_store_busy", busy_o, 1);
      end else begin
        chk("a_valid_rise", data_valid_o, 1);
        chk("a_data", data_o, 8'hA5);
        chk("a_data_ch", data_ch_o, 0);
        chk("a_busy_fall", busy_o, 0);
      end
    end
    @(posedge clk_i); #1;

    // Table of one-shot scans
    tbl[0] = '{4'b1010, {8'hFF, 8'h33, 8'h10, 8'h44}, 2, 2'd1, 8'h10, 2'd3, 8'hFF};
    tbl[1] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'h5A}, 1, 2'd0, 8'h5A, 2'd0, 8'h00};
    tbl[2] = '{4'b1000, {8'h80, 8'h01, 8'h02, 8'h03}, 1, 2'd3, 8'h80, 2'd0, 8'h00};
    tbl[3] = '{4'b0110, {8'h11, 8'h7F, 8'h01, 8'h22}, 2, 2'd1, 8'h01, 2'd2, 8'h7F};
    tbl[4] = '{4'b1001, {8'hC3, 8'h00, 8'h00, 8'h3C}, 2, 2'd0, 8'h3C, 2'd3, 8'hC3};
    tbl[5] = '{4'b0100, {8'h99, 8'h00, 8'h77, 8'h66}, 1, 2'd2, 8'h00, 2'd0, 8'h00};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < CHN; i++) vin[i] = tbl[t].v[i];
      ch_mask_i = tbl[t].mask; data_ready_i = 1; start_i = 1;
      got = 0;
      for (c = 0; c < 200 && !(c > 1 && !busy_o && !data_valid_o); c++) begin
        @(posedge clk_i); #1 start_i = 0;
        @(negedge clk_i);
        if (sample_o) chk("tbl_mux_in_mask", tbl[t].mask[mux_sel_o], 1);
        if (data_valid_o && data_ready_i) begin
          chk("tbl_ch", data_ch_o, (got == 0) ? tbl[t].ch_a : tbl[t].ch_b);
          chk("tbl_data", data_o, (got == 0) ? tbl[t].d_a : tbl[t].d_b);
          got++;
        end
      end
      chk("tbl_count", got, tbl[t].n);
      chk("tbl_idle", busy_o, 0);
    end

    // Backpressure: first result held, FSM stalls in STORE on ch1's final code
    @(posedge clk_i); #1;
    vin[0] = 8'h2C; vin[1] = 8'h6B; ch_mask_i = 4'b0011; data_ready_i = 0; start_i = 1;
    @(posedge clk_i); #1 start_i = 0;
    repeat (2 * LAT + 10) @(posedge clk_i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_valid", data_valid_o, 1);
      chk("bp_data", data_o, 8'h2C);
      chk("bp_busy", busy_o, 1);
      chk("bp_mux", mux_sel_o, 1);
      chk("bp_dac_stable", dac_o, 8'h6B);
      chk("bp_sample", sample_o, 0);
    end
    @(posedge clk_i); #1 data_ready_i = 1;
    get_result("bp_first", 2'd0, 8'h2C);
    get_result("bp_second", 2'd1, 8'h6B);
    @(negedge clk_i);
    chk("bp_valid_clear", data_valid_o, 0);
    chk("bp_idle", busy_o, 0);

    // Continuous scan with a mid-scan mask change, then stop
    @(posedge clk_i); #1;
    vin[0] = 8'h3A; vin[2] = 8'hC5; ch_mask_i = 4'b0001; continuous_i = 1; start_i = 1;
    @(posedge clk_i); #1 start_i = 0; ch_mask_i = 4'b0100;
    get_result("cont_first", 2'd0, 8'h3A);
    continuous_i = 0;
    get_result("cont_relatched", 2'd2, 8'hC5);
    got = 0;
    repeat (2 * LAT) begin
      @(negedge clk_i);
      if (data_valid_o) got++;
    end
    chk("cont_no_more", got, 0);
    chk("cont_idle", busy_o, 0);

    // start with an empty mask is ignored
    @(posedge clk_i); #1 ch_mask_i = '0; start_i = 1;
    repeat (3) begin
      @(negedge clk_i);
      chk("zmask_busy", busy_o, 0);
      chk("zmask_sample", sample_o, 0);
    end
    start_i = 0;

    // Reset in the middle of CONVERT
    @(posedge clk_i); #1 ch_mask_i = 4'b0001; vin[0] = 8'h5F; start_i = 1;
    @(posedge clk_i); #1 start_i = 0;
    repeat (SMP + 4) @(posedge clk_i);
    #1 chk("pre_rst_sample", sample_o, 0);
    chk("pre_rst_busy", busy_o, 1);
    #1 rst_ni = 0;
    #1;
    chk("mid_rst_dac", dac_o, 8'h80);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", data_valid_o, 0);
    chk("mid_rst_mux", mux_sel_o, 0);
    chk("mid_rst_data", data_o, 0);
    @(negedge clk_i) rst_ni = 1;
    got = 0;
    repeat (2 * LAT) begin
      @(negedge clk_i);
      if (data_valid_o || busy_o) got++;
    end
    chk("rst_no_result", got, 0);

    // SETTLE=0 instance: one bit per cycle, rail values
    for (int t = 0; t < 2; t++) begin
      ev = (t == 0) ? 8'h00 : 8'hFF;
      vin_z[0] = ev; mask_z = 4'b0001; ready_z = 1;
      @(posedge clk_i); #1 start_z = 1;
      for (k = 0; k < 40; k++) begin
        @(posedge clk_i);
        @(negedge clk_i);
        start_z = 0;
        if (k >= SMP && k < SMP + RES)
          chk("z_dac_trial", dac_z,
              32'(((int'(ev) >> (RES - (k - SMP))) << (RES - (k - SMP))) | (1 << (RES - 1 - (k - SMP)))));
        if (valid_z) break;
      end
      chk("z_latency", k, LAT0);
      chk("z_data", data_z, ev);
      chk("z_ch", dch_z, 0);
      @(posedge clk_i); #1;
    end

    // Randomized one-shot scans with random backpressure against a queue model
    for (int it = 0; it < 25; it++) begin
      ch_mask_i = CHN'($urandom_range(0, (1 << CHN) - 1));
      for (int i = 0; i < CHN; i++) begin
        vin[i] = RES'($urandom);
        if (ch_mask_i[i]) begin
          r.ch = CHW'(i); r.d = vin[i];
          exp_q.push_back(r);
        end
      end
      start_i = 1;
      for (c = 0; c < 800 && !(c > 1 && exp_q.size() == 0 && !busy_o && !data_valid_o); c++) begin
        @(posedge clk_i); #1 start_i = 0;
        data_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        if (data_valid_o && data_ready_i) begin
          if (exp_q.size() == 0) chk("rnd_unexpected", data_valid_o, 0);
          else begin
            r = exp_q.pop_front();
            chk("rnd_ch", data_ch_o, r.ch);
            chk("rnd_data", data_o, r.d);
          end
        end
      end
      chk("rnd_drained", exp_q.size(), 0);
      chk("rnd_idle", busy_o, 0);
      exp_q.delete();
      @(posedge clk_i); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
